// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command responder.
//   SYNC_BYTE / ACK_BYTE / NAK_BYTE : framing and response byte values
//   CMD_WR_BIT                      : CMD bit selecting write (1) or read (0)
//   state_t                         : frame parser FSM states
//   tx_state_t                      : response sequencer FSM states
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'h55;
    localparam logic [7:0] ACK_BYTE   = 8'h06;
    localparam logic [7:0] NAK_BYTE   = 8'h15;
    localparam int         CMD_WR_BIT = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_DATA,
        ST_GET_CHK,
        ST_EXEC,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT_OK,
        TX_WAIT_LOW
    } tx_state_t;

    function automatic logic cmd_is_write(input logic [7:0] cmd);
        return cmd[CMD_WR_BIT];
    endfunction

endpackage

// File: rtl/uart_cmd_tx_seq.sv
// Response sequencer: buffers 1..3 bytes and hands them to the UART TX one at
// a time using the tx_load / tx_load_ok handshake.
//   sys_clk, rst_n     : clock, asynchronous active-low reset
//   start, cnt, b0..b2 : load the buffer (cnt = number of bytes, 1..3); only
//                        honoured while the sequencer is idle
//   tx_load_ok         : UART TX ready; falls one cycle after an accepted load
//   tx_data, tx_load   : byte and single-cycle load strobe to the UART TX
//   done               : strobe in the cycle the last byte is launched
// Handshake: a byte is launched (tx_load pulses) only in a cycle where
// tx_load_ok is 1; the next byte waits until tx_load_ok has been seen low
// and then high again. tx_data is held until the next launch.
module uart_cmd_tx_seq
    import uart_cmd_pkg::*;
(
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] cnt,
    input  logic [7:0] b0,
    input  logic [7:0] b1,
    input  logic [7:0] b2,
    input  logic       tx_load_ok,
    output logic [7:0] tx_data,
    output logic       tx_load,
    output logic       done
);

    tx_state_t  st_q, st_d;
    logic [7:0] b0_q, b1_q, b2_q;
    logic [1:0] idx_q, last_q;
    logic       fire;
    logic [7:0] cur_byte;

    always_comb begin
        st_d = st_q;
        fire = 1'b0;
        case (st_q)
            TX_IDLE:     if (start) st_d = TX_WAIT_OK;
            TX_WAIT_OK:  if (tx_load_ok) begin
                             fire = 1'b1;
                             st_d = (idx_q == last_q) ? TX_IDLE : TX_WAIT_LOW;
                         end
            TX_WAIT_LOW: if (!tx_load_ok) st_d = TX_WAIT_OK;
            default:     st_d = TX_IDLE;
        endcase
    end

    always_comb begin
        case (idx_q)
            2'd0:    cur_byte = b0_q;
            2'd1:    cur_byte = b1_q;
            default: cur_byte = b2_q;
        endcase
    end

    // Combinational so the parser can leave its RESP state on the same edge
    // that raises tx_load for the final byte.
    assign done = fire && (idx_q == last_q);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= TX_IDLE;
            b0_q    <= 8'h00;
            b1_q    <= 8'h00;
            b2_q    <= 8'h00;
            idx_q   <= 2'd0;
            last_q  <= 2'd0;
            tx_data <= 8'h00;
            tx_load <= 1'b0;
        end else begin
            st_q    <= st_d;
            tx_load <= fire;
            if (st_q == TX_IDLE && start) begin
                b0_q   <= b0;
                b1_q   <= b1;
                b2_q   <= b2;
                idx_q  <= 2'd0;
                last_q <= cnt - 2'd1;
            end
            if (fire) begin
                tx_data <= cur_byte;
                idx_q   <= idx_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Device-side host command responder. Parses SYNC|CMD|[DATA]|CHK frames from
// the UART RX byte stream, performs one local-bus register access and returns
// ACK (+ read data and checksum) or NAK through the UART TX byte port.
//   sys_clk, rst_n                 : clock, asynchronous active-low reset
//   rx_data, rx_valid              : received byte and its single-cycle strobe
//   tx_data, tx_load, tx_load_ok   : response byte port (see uart_cmd_tx_seq)
//   reg_addr, reg_wdata            : register address / write data, held from
//                                    one access until the next
//   reg_we, reg_re                 : single-cycle write / read strobes
//   reg_rdata                      : read data, valid one cycle after reg_re
//   busy                           : high from CMD byte until last byte launched
//   frame_err                      : strobe on checksum/address error or timeout
// Build option: define UART_CMD_TIMEOUT_EN to abort a frame when more than
// TIMEOUT_CYC cycles pass between bytes; otherwise the parser waits forever.
// RX bytes arriving while executing or responding are dropped (half-duplex).
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int SYSCLK_F    = 24000000,
    parameter int ADDR_W      = 7,
    parameter int TIMEOUT_CYC = SYSCLK_F / 50
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_load,
    input  logic              tx_load_ok,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              frame_err
);

    state_t     state_q, state_d;
    logic [7:0] cmd_q, data_q;
    logic       cmd_load, data_load, exec_load, err_d;
    logic       seq_start, seq_done;
    logic [1:0] seq_cnt;
    logic [7:0] seq_b0;
    logic       in_get, chk_ok, addr_ok, timeout;

    assign in_get  = (state_q == ST_GET_CMD) || (state_q == ST_GET_DATA) ||
                     (state_q == ST_GET_CHK);
    assign chk_ok  = rx_data == (cmd_is_write(cmd_q) ? (cmd_q ^ data_q) : cmd_q);
    // CMD address bits above ADDR_W must be zero.
    assign addr_ok = (7'(cmd_q[6:0]) >> ADDR_W) == 7'd0;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)                  to_cnt <= '0;
        else if (in_get && !rx_valid) to_cnt <= to_cnt + TO_W'(1);
        else                         to_cnt <= '0;
    end

    assign timeout = in_get && !rx_valid && (to_cnt == TO_W'(TIMEOUT_CYC));
`else
    logic unused_cfg;
    assign unused_cfg = ^{32'(TIMEOUT_CYC)};
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cmd_load  = 1'b0;
        data_load = 1'b0;
        exec_load = 1'b0;
        err_d     = 1'b0;
        seq_start = 1'b0;
        seq_cnt   = 2'd1;
        seq_b0    = ACK_BYTE;
        case (state_q)
            ST_IDLE:     if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_GET_CMD;
            ST_GET_CMD:  if (rx_valid) begin
                             cmd_load = 1'b1;
                             state_d  = cmd_is_write(rx_data) ? ST_GET_DATA : ST_GET_CHK;
                         end
            ST_GET_DATA: if (rx_valid) begin
                             data_load = 1'b1;
                             state_d   = ST_GET_CHK;
                         end
            ST_GET_CHK:  if (rx_valid) begin
                             if (chk_ok && addr_ok) begin
                                 exec_load = 1'b1;
                                 state_d   = ST_EXEC;
                             end else begin
                                 seq_start = 1'b1;
                                 seq_b0    = NAK_BYTE;
                                 err_d     = 1'b1;
                                 state_d   = ST_RESP;
                             end
                         end
            ST_EXEC:     if (cmd_is_write(cmd_q)) begin
                             seq_start = 1'b1;
                             state_d   = ST_RESP;
                         end else begin
                             state_d   = ST_RD_WAIT;
                         end
            // reg_rdata is valid in this cycle; it goes straight into the
            // sequencer buffer together with its checksum.
            ST_RD_WAIT:  begin
                             seq_start = 1'b1;
                             seq_cnt   = 2'd3;
                             state_d   = ST_RESP;
                         end
            ST_RESP:     if (seq_done) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (timeout) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cmd_q     <= 8'h00;
            data_q    <= 8'h00;
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_err <= err_d;
            if (cmd_load)  cmd_q  <= rx_data;
            if (data_load) data_q <= rx_data;
            // Bus address/data change only on entry to EXEC, so they are
            // stable for the whole strobe cycle.
            if (exec_load) begin
                reg_addr <= cmd_q[ADDR_W-1:0];
                if (cmd_is_write(cmd_q)) reg_wdata <= data_q;
            end
        end
    end

    assign reg_we = (state_q == ST_EXEC) && cmd_is_write(cmd_q);
    assign reg_re = (state_q == ST_EXEC) && !cmd_is_write(cmd_q);
    assign busy   = (state_q == ST_GET_DATA) || (state_q == ST_GET_CHK) ||
                    (state_q == ST_EXEC) || (state_q == ST_RD_WAIT) ||
                    (state_q == ST_RESP);

    uart_cmd_tx_seq u_tx_seq (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .start      (seq_start),
        .cnt        (seq_cnt),
        .b0         (seq_b0),
        .b1         (reg_rdata),
        .b2         (reg_rdata ^ ACK_BYTE),
        .tx_load_ok (tx_load_ok),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .done       (seq_done)
    );

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder (ADDR_W=4, TIMEOUT_CYC=100).
// A small UART TX model drops tx_load_ok for a few cycles after every load;
// a register model returns rd_val only in the cycle after reg_re.
module tb_uart_cmd_responder;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_load_ok;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 sys_clk = ~sys_clk;

    uart_cmd_responder #(
        .SYSCLK_F    (24000000),
        .ADDR_W      (4),
        .TIMEOUT_CYC (100)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_load_ok (tx_load_ok),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    // ---------------- environment models ----------------
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rd_val;
    int         tx_rd = 0;
    int         hold;
    int         viol = 0;
    int         we_cnt = 0, re_cnt = 0, err_cnt = 0;
    logic [3:0] we_addr;
    logic [7:0] we_data;

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_load_ok <= 1'b1;
            hold       <= 0;
            reg_rdata  <= 8'h00;
        end else begin
            reg_rdata <= reg_re ? rd_val : 8'h00;
            if (tx_load) begin
                tx_q.push_back(tx_data);
                if (!tx_load_ok) viol <= viol + 1;
                tx_load_ok <= 1'b0;
                hold       <= 4;
            end else if (!tx_load_ok) begin
                if (hold == 0) tx_load_ok <= 1'b1;
                else           hold <= hold - 1;
            end
            if (reg_we) begin
                we_cnt  <= we_cnt + 1;
                we_addr <= reg_addr;
                we_data <= reg_wdata;
            end
            if (reg_re)    re_cnt  <= re_cnt + 1;
            if (frame_err) err_cnt <= err_cnt + 1;
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge sys_clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (busy && n < 500) begin
            @(negedge sys_clk);
            n++;
        end
        check({tag, "_busy_drop"}, 32'(n < 500), 1);
        idle(3);
    endtask

    // Compares the TX bytes seen since the last call against exp_q.
    task automatic check_tx(input string tag);
        int n = exp_q.size();
        check({tag, "_tx_count"}, 32'(tx_q.size() - tx_rd), 32'(n));
        for (int i = 0; i < n; i++) begin
            logic [7:0] e = exp_q.pop_front();
            if (tx_rd + i < tx_q.size()) check({tag, "_tx_byte"}, 32'(tx_q[tx_rd + i]), 32'(e));
        end
        tx_rd = tx_q.size();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int we0, re0, err0, n;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        rd_val   = 8'h00;
        idle(3);
        check("rst_tx_load", 32'(tx_load), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_we_re", 32'({reg_we, reg_re}), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_addr_wdata", 32'({reg_addr, reg_wdata}), 0);
        rst_n = 1'b1;
        idle(2);

        // Write 0x3C to addr 5
        we0 = we_cnt; err0 = err_cnt;
        send_byte(8'h55); send_byte(8'h85); send_byte(8'h3C); send_byte(8'hB9);
        check("wr_exec_we", 32'({busy, reg_we, reg_re}), 32'b110);
        check("wr_exec_addr", 32'({reg_addr, reg_wdata}), 32'h53C);
        wait_done("wr");
        check("wr_we_count", 32'(we_cnt - we0), 1);
        check("wr_addr", 32'(we_addr), 32'h5);
        check("wr_data", 32'(we_data), 32'h3C);
        check("wr_no_err", 32'(err_cnt - err0), 0);
        check("wr_busy_low", 32'(busy), 0);
        exp_q.push_back(8'h06);
        check_tx("wr");

        // Read addr 5 returning 0xA7
        rd_val = 8'hA7; re0 = re_cnt; we0 = we_cnt;
        send_byte(8'h55); send_byte(8'h05); send_byte(8'h05);
        check("rd_exec_re", 32'({busy, reg_we, reg_re}), 32'b101);
        wait_done("rd");
        check("rd_re_count", 32'(re_cnt - re0), 1);
        check("rd_no_we", 32'(we_cnt - we0), 0);
        exp_q.push_back(8'h06); exp_q.push_back(8'hA7); exp_q.push_back(8'hA1);
        check_tx("rd");
        check("rd_wdata_held", 32'(reg_wdata), 32'h3C);

        // Bad checksum
        we0 = we_cnt; err0 = err_cnt;
        send_byte(8'h55); send_byte(8'h85); send_byte(8'h3C); send_byte(8'h00);
        wait_done("badchk");
        check("badchk_no_we", 32'(we_cnt - we0), 0);
        check("badchk_err", 32'(err_cnt - err0), 1);
        exp_q.push_back(8'h15);
        check_tx("badchk");

        // Address outside ADDR_W=4
        re0 = re_cnt; err0 = err_cnt;
        send_byte(8'h55); send_byte(8'h15); send_byte(8'h15);
        wait_done("badaddr");
        check("badaddr_no_re", 32'(re_cnt - re0), 0);
        check("badaddr_err", 32'(err_cnt - err0), 1);
        exp_q.push_back(8'h15);
        check_tx("badaddr");

        // Leading noise then a read
        rd_val = 8'h5A; err0 = err_cnt;
        send_byte(8'h00); send_byte(8'hFF);
        check("noise_busy", 32'(busy), 0);
        send_byte(8'h55); send_byte(8'h05); send_byte(8'h05);
        wait_done("noise");
        check("noise_no_err", 32'(err_cnt - err0), 0);
        exp_q.push_back(8'h06); exp_q.push_back(8'h5A); exp_q.push_back(8'h5C);
        check_tx("noise");

        // 0x55 as the data byte of a write
        send_byte(8'h55); send_byte(8'h83); send_byte(8'h55); send_byte(8'hD6);
        wait_done("wr55");
        check("wr55_addr", 32'(we_addr), 32'h3);
        check("wr55_data", 32'(we_data), 32'h55);
        exp_q.push_back(8'h06);
        check_tx("wr55");

        // Bytes during execute/response are dropped
        rd_val = 8'h11; re0 = re_cnt;
        send_byte(8'h55); send_byte(8'h02); send_byte(8'h02);
        send_byte(8'h55);
        wait_done("drop");
        send_byte(8'h02); send_byte(8'h02);
        idle(20);
        check("drop_re_count", 32'(re_cnt - re0), 1);
        exp_q.push_back(8'h06); exp_q.push_back(8'h11); exp_q.push_back(8'h17);
        check_tx("drop");

`ifdef UART_CMD_TIMEOUT_EN
        err0 = err_cnt;
        send_byte(8'h55); send_byte(8'h85);
        idle(90);
        check("to_not_early", 32'(err_cnt - err0), 0);
        check("to_busy_wait", 32'(busy), 1);
        idle(20);
        check("to_err", 32'(err_cnt - err0), 1);
        check("to_idle", 32'(busy), 0);
`else
        we0 = we_cnt; err0 = err_cnt;
        send_byte(8'h55); send_byte(8'h85);
        idle(200);
        check("nto_no_err", 32'(err_cnt - err0), 0);
        check("nto_busy", 32'(busy), 1);
        send_byte(8'h3C); send_byte(8'hB9);
        wait_done("nto");
        check("nto_we", 32'(we_cnt - we0), 1);
        exp_q.push_back(8'h06);
        check_tx("nto");
`endif
        rd_val = 8'hA7;
        send_byte(8'h55); send_byte(8'h05); send_byte(8'h05);
        wait_done("after");
        exp_q.push_back(8'h06); exp_q.push_back(8'hA7); exp_q.push_back(8'hA1);
        check_tx("after");

        // Reset while waiting to send the second response byte
        rd_val = 8'hC3;
        send_byte(8'h55); send_byte(8'h05); send_byte(8'h05);
        n = 0;
        while (tx_q.size() <= tx_rd && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        check("rst_mid_first_byte", 32'(n < 200), 1);
        idle(1);
        rst_n = 1'b0;
        #1;
        check("rstm_tx_load", 32'(tx_load), 0);
        check("rstm_busy", 32'(busy), 0);
        check("rstm_addr", 32'({reg_addr, reg_we, reg_re, frame_err}), 0);
        idle(2);
        rst_n = 1'b1;
        idle(10);
        check("rstm_partial", 32'(tx_q.size() - tx_rd), 1);
        tx_rd = tx_q.size();
        rd_val = 8'h3E;
        send_byte(8'h55); send_byte(8'h05); send_byte(8'h05);
        wait_done("rstm");
        exp_q.push_back(8'h06); exp_q.push_back(8'h3E); exp_q.push_back(8'h38);
        check_tx("rstm");

        check("tx_load_while_not_ok", 32'(viol), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
